// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables/muxes and the 4-bit alu_op, and stalls on the memory-ready handshake.
module mips_multicycle_control #(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_zero,
    output logic [1:0]  pc_source,
    output logic [3:0]  alu_op,
    output logic [3:0]  state_o,
    output logic        illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_LUI  = 4'b0110;

    localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? HALT : FETCH;

    state_t     state_reg, state_next;
    ctrl_t      ctrl_raw;
    logic       ready;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] r_alu_op;
    logic       r_legal;
    logic [3:0] i_alu_op;
    logic       i_ext_zero;

    assign ready  = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        r_alu_op = ALU_ADD;
        r_legal  = 1'b1;
        case (funct)
            6'h21:   r_alu_op = ALU_ADD;
            6'h23:   r_alu_op = ALU_SUB;
            6'h24:   r_alu_op = ALU_AND;
            6'h25:   r_alu_op = ALU_OR;
            6'h2a:   r_alu_op = ALU_SLT;
            6'h2b:   r_alu_op = ALU_SLTU;
            default: r_legal  = 1'b0;
        endcase
    end

    always_comb begin
        i_alu_op   = ALU_ADD;
        i_ext_zero = 1'b0;
        case (opcode)
            OP_SLTI: i_alu_op = ALU_SLT;
            OP_ANDI: begin i_alu_op = ALU_AND; i_ext_zero = 1'b1; end
            OP_ORI:  begin i_alu_op = ALU_OR;  i_ext_zero = 1'b1; end
            OP_LUI:  begin i_alu_op = ALU_LUI; i_ext_zero = 1'b1; end
            default: i_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl_raw   = '0;
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                ctrl_raw.mem_read  = 1'b1;
                ctrl_raw.alu_src_b = 2'b01;
                ctrl_raw.ir_write  = ready;
                ctrl_raw.pc_write  = ready;
                if (ready) state_next = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched
                ctrl_raw.alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:       state_next = MEM_ADDR;
                    OP_RTYPE:           state_next = EXEC_R;
                    OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI:
                                        state_next = EXEC_I;
                    OP_BEQ, OP_BNE:     state_next = BRANCH;
                    OP_J:               state_next = JUMP;
                    default:            state_next = ILLEGAL_NEXT;
                endcase
            end
            MEM_ADDR: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = 2'b10;
                state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctrl_raw.mem_read = 1'b1;
                ctrl_raw.i_or_d   = 1'b1;
                if (ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                ctrl_raw.mem_write = 1'b1;
                ctrl_raw.i_or_d    = 1'b1;
                if (ready) state_next = FETCH;
            end
            EXEC_R: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_op    = r_legal ? r_alu_op : ALU_ADD;
                state_next = r_legal ? R_WB : ILLEGAL_NEXT;
            end
            R_WB: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.reg_dst   = 1'b1;
                state_next = FETCH;
            end
            EXEC_I: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = 2'b10;
                ctrl_raw.alu_op    = i_alu_op;
                ctrl_raw.ext_zero  = i_ext_zero;
                state_next = I_WB;
            end
            I_WB: begin
                ctrl_raw.reg_write = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ctrl_raw.alu_src_a     = 1'b1;
                ctrl_raw.alu_op        = ALU_SUB;
                ctrl_raw.pc_source     = 2'b01;
                ctrl_raw.pc_write_cond = (opcode == OP_BNE) ? ~zero : zero;
                state_next = FETCH;
            end
            JUMP: begin
                ctrl_raw.pc_write  = 1'b1;
                ctrl_raw.pc_source = 2'b10;
                state_next = FETCH;
            end
            HALT: begin
                ctrl_raw.illegal = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset masks the outputs combinationally so enables drop without waiting for a clock edge
    ctrl_t ctrl;
    assign ctrl = rst ? '0 : ctrl_raw;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign ext_zero      = ctrl.ext_zero;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign illegal       = ctrl.illegal;
    assign state_o       = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: instance 0 traps and handshakes,
// instance 1 treats illegal as NOP and ignores mem_ready.
module tb_mips_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_MEM_WB = 4;
    localparam int S_MEM_WR = 5, S_EXEC_R = 6, S_R_WB = 7, S_EXEC_I = 8, S_I_WB = 9;
    localparam int S_BRANCH = 10, S_JUMP = 11, S_HALT = 12;

    typedef struct {
        int         dut;
        logic [3:0] st;
        logic [19:0] outs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v   [2];
    logic [31:0] instr_v [2];
    logic        zero_v  [2];
    logic        mr_v    [2];
    logic [19:0] obs_v   [2];
    logic [3:0]  st_v    [2];

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] legal_functs [6] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b};
    logic [5:0] i_opcodes    [5] = '{6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic       pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, ez, ill;
        logic [1:0] asb, ps;
        logic [3:0] op, st;
        mips_multicycle_control #(
            .MEM_HANDSHAKE  (gi == 0),
            .TRAP_ON_ILLEGAL(gi == 0)
        ) dut (
            .clk          (clk),
            .rst          (rst_v[gi]),
            .instr        (instr_v[gi]),
            .zero         (zero_v[gi]),
            .mem_ready    (mr_v[gi]),
            .pc_write     (pw),
            .pc_write_cond(pwc),
            .i_or_d       (iod),
            .mem_read     (mrd),
            .mem_write    (mwr),
            .ir_write     (irw),
            .mem_to_reg   (m2r),
            .reg_dst      (rdst),
            .reg_write    (rw),
            .alu_src_a    (asa),
            .alu_src_b    (asb),
            .ext_zero     (ez),
            .pc_source    (ps),
            .alu_op       (op),
            .state_o      (st),
            .illegal      (ill)
        );
        assign obs_v[gi] = {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, ez, ps, op, ill};
        assign st_v[gi]  = st;
    end

    // Reference tables taken straight from the instruction set description
    function automatic int r_op(input logic [5:0] fn);
        case (fn)
            6'h21: return 0;
            6'h23: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h2a: return 4;
            6'h2b: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int i_op(input logic [5:0] opc);
        case (opc)
            6'h09: return 0;
            6'h0a: return 4;
            6'h0c: return 2;
            6'h0d: return 3;
            6'h0f: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal_op(input logic [5:0] opc);
        return (opc == 6'h00) || (opc == 6'h02) || (opc == 6'h04) || (opc == 6'h05) ||
               (opc == 6'h23) || (opc == 6'h2b) || (i_op(opc) >= 0);
    endfunction

    function automatic logic [19:0] exp_outs(input int st, input logic [31:0] ins,
                                             input logic rdy, input logic z);
        logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0;
        logic rw = 0, asa = 0, ez = 0, ill = 0;
        logic [1:0] asb = 0, ps = 0;
        logic [3:0] op = 0;
        case (st)
            S_FETCH:    begin mrd = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            S_DECODE:   asb = 2'b11;
            S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            S_MEM_RD:   begin mrd = 1; iod = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mwr = 1; iod = 1; end
            S_EXEC_R:   begin asa = 1; if (r_op(ins[5:0]) >= 0) op = 4'(r_op(ins[5:0])); end
            S_R_WB:     begin rw = 1; rdst = 1; end
            S_EXEC_I:   begin
                asa = 1; asb = 2'b10; op = 4'(i_op(ins[31:26]));
                ez = (ins[31:26] == 6'h0c) || (ins[31:26] == 6'h0d) || (ins[31:26] == 6'h0f);
            end
            S_I_WB:     rw = 1;
            S_BRANCH:   begin asa = 1; op = 4'd1; ps = 2'b01; pwc = (ins[31:26] == 6'h05) ? ~z : z; end
            S_JUMP:     begin pw = 1; ps = 2'b10; end
            S_HALT:     ill = 1;
            default:    ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, ez, ps, op, ill};
    endfunction

    // Drive one cycle's inputs and queue what the DUT must show during it
    task automatic present(input int d, input logic r, input logic [31:0] ins,
                           input logic mr, input logic z, input int st);
        exp_t e;
        logic rdy = mr | (d == 1);
        e.dut  = d;
        e.st   = r ? 4'd0 : 4'(st);
        e.outs = r ? 20'd0 : exp_outs(st, ins, rdy, z);
        rst_v[d] = r; instr_v[d] = ins; mr_v[d] = mr; zero_v[d] = z;
        q.push_back(e);
    endtask

    task automatic step(input int d, input logic r, input logic [31:0] ins,
                        input logic mr, input logic z, input int st);
        present(d, r, ins, mr, z, st);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic mem_stage(input int d, input logic [31:0] ins, input logic z,
                             input int mw, input int st);
        if (d == 0) begin
            for (int i = 0; i < mw; i++) step(d, 0, ins, 1'b0, z, st);
            step(d, 0, ins, 1'b1, z, st);
        end else begin
            step(d, 0, ins, rbit(), z, st);
        end
    endtask

    // One instruction from FETCH until the FSM is back at FETCH (or halted and reset)
    task automatic run_instr(input int d, input logic [31:0] ins, input logic z,
                             input int fw, input int mw);
        logic [5:0] opc = ins[31:26];
        mem_stage(d, ins, z, fw, S_FETCH);
        step(d, 0, ins, rbit(), z, S_DECODE);
        if (opc == 6'h23) begin
            step(d, 0, ins, rbit(), z, S_MEM_ADDR);
            mem_stage(d, ins, z, mw, S_MEM_RD);
            step(d, 0, ins, rbit(), z, S_MEM_WB);
        end else if (opc == 6'h2b) begin
            step(d, 0, ins, rbit(), z, S_MEM_ADDR);
            mem_stage(d, ins, z, mw, S_MEM_WR);
        end else if (opc == 6'h00) begin
            step(d, 0, ins, rbit(), z, S_EXEC_R);
            if (r_op(ins[5:0]) >= 0) step(d, 0, ins, rbit(), z, S_R_WB);
            else if (d == 0) halt_and_reset(ins, z);
        end else if (i_op(opc) >= 0) begin
            step(d, 0, ins, rbit(), z, S_EXEC_I);
            step(d, 0, ins, rbit(), z, S_I_WB);
        end else if (opc == 6'h04 || opc == 6'h05) begin
            step(d, 0, ins, rbit(), z, S_BRANCH);
        end else if (opc == 6'h02) begin
            step(d, 0, ins, rbit(), z, S_JUMP);
        end else if (d == 0) begin
            halt_and_reset(ins, z);
        end
        $display("dut%0d instr=%h zero=%0d fetch_wait=%0d mem_wait=%0d", d, ins, z, fw, mw);
    endtask

    task automatic halt_and_reset(input logic [31:0] ins, input logic z);
        for (int i = 0; i < 3; i++) step(0, 0, ins, rbit(), z, S_HALT);
        step(0, 1, ins, rbit(), z, S_FETCH);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 12);
        logic [5:0] opc;
        case (k)
            0: r[31:26] = 6'h23;
            1: r[31:26] = 6'h2b;
            2: begin r[31:26] = 6'h00; r[5:0] = legal_functs[$urandom_range(0, 5)]; end
            3: r[31:26] = 6'h00;
            4, 5, 6: r[31:26] = i_opcodes[$urandom_range(0, 4)];
            7: r[31:26] = 6'h04;
            8: r[31:26] = 6'h05;
            9: r[31:26] = 6'h02;
            10: begin
                do opc = 6'($urandom); while (legal_op(opc));
                r[31:26] = opc;
            end
            default: begin r[31:26] = 6'h00; r[5:0] = legal_functs[$urandom_range(0, 5)]; end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (st_v[mon_e.dut] !== mon_e.st || obs_v[mon_e.dut] !== mon_e.outs) begin
                errors++;
                $display("FAIL ctrl dut%0d t=%0t: state=%0d outs=%b, expected state=%0d outs=%b",
                         mon_e.dut, $time, st_v[mon_e.dut], obs_v[mon_e.dut], mon_e.st, mon_e.outs);
            end
        end
    end

    initial begin
        int guard;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; instr_v[d] = '0; zero_v[d] = 1'b0; mr_v[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 1, 32'h00221821, 1'b1, 1'b0, S_FETCH);

        run_instr(0, 32'h00221821, 1'b0, 0, 0);
        run_instr(0, 32'h8c220004, 1'b0, 0, 2);
        run_instr(0, 32'h10220003, 1'b1, 0, 0);
        run_instr(0, 32'h10220003, 1'b0, 0, 0);
        run_instr(0, 32'h14220003, 1'b1, 0, 0);
        run_instr(0, 32'h14220003, 1'b0, 0, 0);
        run_instr(0, 32'h34220f0f, 1'b0, 1, 0);
        run_instr(0, 32'h3c011234, 1'b0, 0, 0);
        run_instr(0, 32'hfc000000, 1'b0, 0, 0);
        run_instr(0, 32'hac220008, 1'b0, 2, 3);

        // Asynchronous reset while a store is waiting on memory
        step(0, 0, 32'hac220008, 1'b1, 1'b0, S_FETCH);
        step(0, 0, 32'hac220008, 1'b0, 1'b0, S_DECODE);
        step(0, 0, 32'hac220008, 1'b0, 1'b0, S_MEM_ADDR);
        present(0, 0, 32'hac220008, 1'b0, 1'b0, S_MEM_WR);
        #6;
        rst_v[0] = 1'b1;
        #1;
        checks++;
        if (obs_v[0] !== 20'd0 || st_v[0] !== 4'd0) begin
            errors++;
            $display("FAIL async_rst: state=%0d outs=%b, expected state=0 outs=0", st_v[0], obs_v[0]);
        end
        @(posedge clk);
        #1;
        step(0, 1, 32'hac220008, 1'b0, 1'b0, S_FETCH);

        for (int n = 0; n < 150; n++)
            run_instr(0, rand_instr(), rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
        step(0, 1, 32'h0, 1'b0, 1'b0, S_FETCH);

        for (int i = 0; i < 2; i++) step(1, 1, 32'h0, 1'b1, 1'b0, S_FETCH);
        run_instr(1, 32'hfc000000, 1'b0, 0, 0);
        run_instr(1, 32'h8c220004, 1'b0, 0, 0);
        run_instr(1, 32'hac220008, 1'b1, 0, 0);
        for (int n = 0; n < 80; n++)
            run_instr(1, rand_instr(), rbit(), 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, expected pending=0", q.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
